mmio_io_ctrl: RTL
=================

Name: mmio_io_ctrl

Overview:
- Parametrised memory-mapped I/O controller for the pipelined DBITS-wide processor. It replaces the ad-hoc HEX/LEDR/LEDG store logic and the raw KEY/SW read mux in the core top.
- Adds synchronised and debounced key/switch inputs, sticky key-press status with write-1-to-clear, and a key interrupt enable.
- Sits on the data-memory port: the core drives ADDR/DIN/WE from its write-back stage and muxes DOUT in when SEL=1.

Parameters:
- DBITS, 16, data/address width (>=16)
- NKEYS, 4, number of key inputs (<=DBITS)
- NSW, 10, number of switch inputs (<=DBITS)
- NLEDR, 10, red LED width
- NLEDG, 8, green LED width
- DEB_CYCLES, 4, consecutive stable cycles needed to accept an input change (>=1)

Ports:
- CLK  in  1  system clock, all state on posedge
- RESET_N  in  1  asynchronous active-low reset
- ADDR  in  DBITS  byte address from core data port
- DIN  in  DBITS  store data
- WE  in  1  store strobe, qualified by address decode
- DOUT  out  DBITS  read data, combinational from ADDR
- SEL  out  1  ADDR[DBITS-1:DBITS-4]==4'hF (I/O space)
- KEY  in  NKEYS  raw keys, active-low (pressed=0)
- SW  in  NSW  raw switches
- HEX  out  DBITS  seven-segment value register
- LEDR  out  NLEDR  red LED register
- LEDG  out  NLEDG  green LED register
- IRQ  out  1  |(KSTAT & KIEN), plus timer tick when enabled

Behaviour:
- Reset (async, RESET_N=0):
  - HEX, LEDR, LEDG, KSTAT, KIEN = 0.
  - Key sync/debounced state = all 1s; switch sync/debounced state = 0; debounce counters = 0.
  - IRQ = 0. Reset mid-debounce discards partial counts.
- Input path, per bit:
  - 2-FF synchroniser, then debounce.
  - Each edge where sync!=deb increments that bit's counter.
  - Any edge where sync==deb clears the counter.
  - On the DEB_CYCLES-th consecutive differing edge: deb<=sync, counter<=0.
  - Pin-to-KDATA latency is exactly 2+DEB_CYCLES edges. A glitch shorter than DEB_CYCLES is ignored.
- Key press: a debounced 1->0 transition of key i sets KSTAT[i] on the same edge deb updates.
- Address map (full DBITS compare; upper bits all 1):
  - FFF0 KDATA R: debounced keys, zero-extended.
  - FFF2 SDATA R: debounced switches.
  - FFF4 KSTAT R/W1C: writing 1 to bit i clears it.
  - FFF6 KIEN R/W.
  - FFF8 HEX R/W.
  - FFFA LEDR R/W: DIN[NLEDR-1:0].
  - FFFC LEDG R/W: DIN[NLEDG-1:0].
  - Any other address reads 16'hDEAD (zero-extended to DBITS); writes to it are ignored.
- Writes commit on posedge CLK when WE && address match. Reads are 0-latency combinational on registered state; a same-cycle write returns the old value.
- W1C clear and a new press edge on the same bit in the same cycle: the set wins.
- Writes to read-only addresses (KDATA, SDATA) have no effect.
- DOUT for narrow registers is zero-extended. SEL is independent of WE.

Optional Feature:
- Macro: MMIO_IO_CTRL_TIMER_EN.
- With the macro:
  - FFE0 TLIM R/W; writing it also clears TCNT.
  - FFE2 TCNT R.
  - FFE4 TCTL: bit0 enable R/W; bit1 tick sticky, W1C.
  - When enabled, TCNT increments each cycle. When TCNT==TLIM: TCNT<=0 and tick<=1 (set wins over W1C).
  - IRQ also ORs (tick & TCTL[2]), where TCTL[2] is the tick interrupt enable.
  - All timer registers reset to 0.
- Without the macro: FFE0–FFE4 read DEAD, writes are ignored, and no timer logic is present.

Decomposition:
- Package mmio_io_pkg holds:
  - the address constants (ADDR_KDATA, ADDR_SDATA, ADDR_KSTAT, ADDR_KIEN, ADDR_HEX, ADDR_LEDR, ADDR_LEDG, ADDR_TLIM, ADDR_TCNT, ADDR_TCTL);
  - the DEAD read constant;
  - the TCTL bit indices.
- Sub-module io_debounce (parameters W, DEB_CYCLES, RST_VAL): synchroniser plus per-bit counters, outputs a W-bit debounced vector. Instantiated once for keys (RST_VAL all 1s) and once for switches (RST_VAL 0).

Test Plan:
- Reset then read all addresses -> KDATA=000F, KSTAT=0, HEX=0, LEDR=0, LEDG=0, FFE8 reads DEAD, IRQ=0.
- WE with ADDR=FFF8, DIN=BEEF; then ADDR=FFFA, DIN=FFFF -> HEX=BEEF next cycle, LEDR=3FF, DOUT@FFFA=03FF; same-cycle readback of FFF8 shows the old value.
- KEY[1] driven low and held (DEB_CYCLES=4) -> KDATA=000D after exactly 6 edges, KSTAT=0002. With KIEN=0002, IRQ=1.
- KEY[2] low for 3 cycles only -> KDATA and KSTAT unchanged.
- With KSTAT=0002: write FFF4 DIN=0002 -> KSTAT=0, IRQ=0. Write 0002 on the same edge a new KEY[1] press is accepted -> KSTAT stays 0002.
- With the timer macro: TLIM=3, TCTL=0005 -> TCNT runs 0,1,2,3,0; tick and IRQ assert on the wrap edge; write TCTL=0007 clears the tick.

Source files
------------

// File: rtl/mmio_io_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mmio_io_pkg
// Shared constants for the memory-mapped I/O controller:
//   - 16-bit low halves of the register addresses (upper address bits are
//     all 1s for any DBITS >= 16)
//   - the read value returned for unmapped addresses
//   - bit positions inside the timer control register
// ---------------------------------------------------------------------------
package mmio_io_pkg;

  localparam logic [15:0] ADDR_KDATA = 16'hFFF0;
  localparam logic [15:0] ADDR_SDATA = 16'hFFF2;
  localparam logic [15:0] ADDR_KSTAT = 16'hFFF4;
  localparam logic [15:0] ADDR_KIEN  = 16'hFFF6;
  localparam logic [15:0] ADDR_HEX   = 16'hFFF8;
  localparam logic [15:0] ADDR_LEDR  = 16'hFFFA;
  localparam logic [15:0] ADDR_LEDG  = 16'hFFFC;
  localparam logic [15:0] ADDR_TLIM  = 16'hFFE0;
  localparam logic [15:0] ADDR_TCNT  = 16'hFFE2;
  localparam logic [15:0] ADDR_TCTL  = 16'hFFE4;

  // Value read back from any address that is not decoded.
  localparam logic [15:0] RD_DEAD = 16'hDEAD;

  // Timer control register bit positions.
  localparam int TCTL_EN   = 0;  // counter enable, R/W
  localparam int TCTL_TICK = 1;  // sticky wrap flag, W1C
  localparam int TCTL_TIE  = 2;  // tick interrupt enable, R/W

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// ---------------------------------------------------------------------------
// mmio_io_ctrl_if
// Data-memory-port bus between the core (master) and the I/O controller
// (slave).
//   ADDR  core -> ctrl  byte address
//   DIN   core -> ctrl  store data
//   WE    core -> ctrl  store strobe
//   DOUT  ctrl -> core  combinational read data
//   SEL   ctrl -> core  address lies in I/O space (top nibble all 1s)
// ---------------------------------------------------------------------------
interface mmio_io_ctrl_if #(
  parameter int DBITS = 16
);
  logic [DBITS-1:0] ADDR;
  logic [DBITS-1:0] DIN;
  logic             WE;
  logic [DBITS-1:0] DOUT;
  logic             SEL;

  modport master (output ADDR, output DIN, output WE, input DOUT, input SEL);
  modport slave  (input ADDR, input DIN, input WE, output DOUT, output SEL);
endinterface

// File: rtl/mmio_io_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// io_debounce
// Two-flop synchroniser followed by a per-bit debouncer. A bit's debounced
// value follows the synchronised value only after DEB_CYCLES consecutive
// clock edges on which the two differ; any edge on which they agree
// restarts the count. Pin-to-output latency is 2 + DEB_CYCLES edges.
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (state -> RST_VAL, counts -> 0)
//   i_raw    W raw asynchronous inputs
//   o_deb    W debounced outputs (registered)
//   o_fall   W strobes, high in the cycle whose edge moves o_deb 1->0
// ---------------------------------------------------------------------------
module io_debounce #(
  parameter int             W          = 4,
  parameter int             DEB_CYCLES = 4,
  parameter logic [W-1:0]   RST_VAL    = {W{1'b0}}
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_deb,
  output logic [W-1:0] o_fall
);

  localparam int            CW   = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [W-1:0]  r_sync1;
  logic [W-1:0]  r_sync2;
  logic [W-1:0]  r_deb;
  logic [CW-1:0] r_cnt [W];
  logic [W-1:0]  w_diff;
  logic [W-1:0]  w_accept;

  // Per-bit disagreement and "this edge completes the stable run" flags.
  always_comb begin
    w_diff   = r_sync2 ^ r_deb;
    w_accept = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      if (w_diff[i] && (r_cnt[i] == LAST)) begin
        w_accept[i] = 1'b1;
      end else begin
        w_accept[i] = 1'b0;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= RST_VAL;
      r_sync2 <= RST_VAL;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Stable-run counters; cleared on agreement and on acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < W; i++) begin
        r_cnt[i] <= {CW{1'b0}};
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (!w_diff[i] || w_accept[i]) begin
          r_cnt[i] <= {CW{1'b0}};
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Debounced state takes the synchronised value once the run completes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_deb <= RST_VAL;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (w_accept[i]) begin
          r_deb[i] <= r_sync2[i];
        end
      end
    end
  end

  assign o_deb  = r_deb;
  // An accepted change on a bit currently at 1 is a 1->0 transition.
  assign o_fall = w_accept & r_deb;

endmodule

// File: rtl/mmio_io_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_io_ctrl
// Memory-mapped I/O controller on the core's data-memory port. Provides
// debounced key/switch inputs, sticky key-press status (write-1-to-clear),
// key interrupt enables and the HEX/LEDR/LEDG output registers.
//
// Optional timer: define MMIO_IO_CTRL_TIMER_EN to add TLIM/TCNT/TCTL at
// FFE0/FFE2/FFE4. Without it those addresses read DEAD and ignore writes.
//
// Ports:
//   CLK      system clock, all state on posedge
//   RESET_N  asynchronous active-low reset
//   bus      mmio_io_ctrl_if slave: ADDR, DIN, WE in; DOUT, SEL out
//   KEY      raw active-low keys (pressed = 0)
//   SW       raw switches
//   HEX      seven-segment value register
//   LEDR     red LED register
//   LEDG     green LED register
//   IRQ      |(KSTAT & KIEN), plus timer tick when enabled
// ---------------------------------------------------------------------------
module mmio_io_ctrl
  import mmio_io_pkg::*;
#(
  parameter int DBITS      = 16,
  parameter int NKEYS      = 4,
  parameter int NSW        = 10,
  parameter int NLEDR      = 10,
  parameter int NLEDG      = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  mmio_io_ctrl_if.slave     bus,
  input  logic [NKEYS-1:0]  KEY,
  input  logic [NSW-1:0]    SW,
  output logic [DBITS-1:0]  HEX,
  output logic [NLEDR-1:0]  LEDR,
  output logic [NLEDG-1:0]  LEDG,
  output logic              IRQ
);

  // Widen a 16-bit map address to DBITS with the extra upper bits set.
  function automatic logic [DBITS-1:0] full_addr(input logic [15:0] a);
    return ~(DBITS'(~a));
  endfunction

  localparam logic [DBITS-1:0] A_KDATA = full_addr(ADDR_KDATA);
  localparam logic [DBITS-1:0] A_SDATA = full_addr(ADDR_SDATA);
  localparam logic [DBITS-1:0] A_KSTAT = full_addr(ADDR_KSTAT);
  localparam logic [DBITS-1:0] A_KIEN  = full_addr(ADDR_KIEN);
  localparam logic [DBITS-1:0] A_HEX   = full_addr(ADDR_HEX);
  localparam logic [DBITS-1:0] A_LEDR  = full_addr(ADDR_LEDR);
  localparam logic [DBITS-1:0] A_LEDG  = full_addr(ADDR_LEDG);
  localparam logic [DBITS-1:0] DEAD_X  = DBITS'(RD_DEAD);

  logic [DBITS-1:0] r_hex;
  logic [NLEDR-1:0] r_ledr;
  logic [NLEDG-1:0] r_ledg;
  logic [NKEYS-1:0] r_kstat;
  logic [NKEYS-1:0] r_kien;

  logic [NKEYS-1:0] w_key_deb;
  logic [NKEYS-1:0] w_key_fall;
  logic [NSW-1:0]   w_sw_deb;
  logic [NSW-1:0]   w_unused_sw_fall;
  logic [NKEYS-1:0] w_kstat_clr;
  logic [DBITS-1:0] w_dout;
  logic             w_irq;

  logic w_wr_kstat;
  logic w_wr_kien;
  logic w_wr_hex;
  logic w_wr_ledr;
  logic w_wr_ledg;

  // Keys idle high, so their synchroniser/debounce state resets to 1s.
  io_debounce #(
    .W          (NKEYS),
    .DEB_CYCLES (DEB_CYCLES),
    .RST_VAL    ({NKEYS{1'b1}})
  ) u_key_deb (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_raw   (KEY),
    .o_deb   (w_key_deb),
    .o_fall  (w_key_fall)
  );

  io_debounce #(
    .W          (NSW),
    .DEB_CYCLES (DEB_CYCLES),
    .RST_VAL    ({NSW{1'b0}})
  ) u_sw_deb (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_raw   (SW),
    .o_deb   (w_sw_deb),
    .o_fall  (w_unused_sw_fall)
  );

  assign w_wr_kstat = bus.WE && (bus.ADDR == A_KSTAT);
  assign w_wr_kien  = bus.WE && (bus.ADDR == A_KIEN);
  assign w_wr_hex   = bus.WE && (bus.ADDR == A_HEX);
  assign w_wr_ledr  = bus.WE && (bus.ADDR == A_LEDR);
  assign w_wr_ledg  = bus.WE && (bus.ADDR == A_LEDG);

`ifdef MMIO_IO_CTRL_TIMER_EN
  localparam logic [DBITS-1:0] A_TLIM = full_addr(ADDR_TLIM);
  localparam logic [DBITS-1:0] A_TCNT = full_addr(ADDR_TCNT);
  localparam logic [DBITS-1:0] A_TCTL = full_addr(ADDR_TCTL);

  logic [DBITS-1:0] r_tlim;
  logic [DBITS-1:0] r_tcnt;
  logic             r_ten;
  logic             r_tick;
  logic             r_tie;
  logic             w_wr_tlim;
  logic             w_wr_tctl;
  logic             w_wrap;

  assign w_wr_tlim = bus.WE && (bus.ADDR == A_TLIM);
  assign w_wr_tctl = bus.WE && (bus.ADDR == A_TCTL);
  assign w_wrap    = r_ten && (r_tcnt == r_tlim);

  // Limit register and free-running counter; a TLIM write restarts the count.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tlim <= {DBITS{1'b0}};
      r_tcnt <= {DBITS{1'b0}};
    end else begin
      if (w_wr_tlim) begin
        r_tlim <= bus.DIN;
        r_tcnt <= {DBITS{1'b0}};
      end else if (w_wrap) begin
        r_tcnt <= {DBITS{1'b0}};
      end else if (r_ten) begin
        r_tcnt <= r_tcnt + DBITS'(1);
      end
    end
  end

  // Timer control: enable/IE are plain R/W, tick is sticky with set priority.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ten  <= 1'b0;
      r_tie  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      if (w_wr_tctl) begin
        r_ten <= bus.DIN[TCTL_EN];
        r_tie <= bus.DIN[TCTL_TIE];
      end
      r_tick <= w_wrap | (r_tick & ~(w_wr_tctl & bus.DIN[TCTL_TICK]));
    end
  end
`endif

  // Plain R/W output and interrupt-enable registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hex  <= {DBITS{1'b0}};
      r_ledr <= {NLEDR{1'b0}};
      r_ledg <= {NLEDG{1'b0}};
      r_kien <= {NKEYS{1'b0}};
    end else begin
      if (w_wr_hex) begin
        r_hex <= bus.DIN;
      end
      if (w_wr_ledr) begin
        r_ledr <= bus.DIN[NLEDR-1:0];
      end
      if (w_wr_ledg) begin
        r_ledg <= bus.DIN[NLEDG-1:0];
      end
      if (w_wr_kien) begin
        r_kien <= bus.DIN[NKEYS-1:0];
      end
    end
  end

  // W1C mask for KSTAT; only meaningful on a KSTAT store.
  always_comb begin
    w_kstat_clr = {NKEYS{1'b0}};
    if (w_wr_kstat) begin
      w_kstat_clr = bus.DIN[NKEYS-1:0];
    end else begin
      w_kstat_clr = {NKEYS{1'b0}};
    end
  end

  // Sticky key-press status; a press on the same edge beats the clear.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_kstat <= {NKEYS{1'b0}};
    end else begin
      r_kstat <= (r_kstat & ~w_kstat_clr) | w_key_fall;
    end
  end

  // Zero-latency read mux over registered state only.
  always_comb begin
    w_dout = DEAD_X;
    case (bus.ADDR)
      A_KDATA: w_dout = DBITS'(w_key_deb);
      A_SDATA: w_dout = DBITS'(w_sw_deb);
      A_KSTAT: w_dout = DBITS'(r_kstat);
      A_KIEN:  w_dout = DBITS'(r_kien);
      A_HEX:   w_dout = r_hex;
      A_LEDR:  w_dout = DBITS'(r_ledr);
      A_LEDG:  w_dout = DBITS'(r_ledg);
`ifdef MMIO_IO_CTRL_TIMER_EN
      A_TLIM:  w_dout = r_tlim;
      A_TCNT:  w_dout = r_tcnt;
      A_TCTL:  w_dout = DBITS'({r_tie, r_tick, r_ten});
`endif
      default: w_dout = DEAD_X;
    endcase
  end

  // Interrupt combines registered status bits only, so it is glitch-free.
  always_comb begin
    w_irq = |(r_kstat & r_kien);
`ifdef MMIO_IO_CTRL_TIMER_EN
    w_irq = w_irq | (r_tick & r_tie);
`endif
  end

  assign bus.DOUT = w_dout;
  assign bus.SEL  = &bus.ADDR[DBITS-1:DBITS-4];
  assign HEX      = r_hex;
  assign LEDR     = r_ledr;
  assign LEDG     = r_ledg;
  assign IRQ      = w_irq;

endmodule
